// File: rtl/fetch_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
package fetch_pkg;
  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {pc, inst} buffer that parks a response while decode is stalled.
module fetch_hold_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] inst_in,
  output logic            full,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] inst_out
);
  logic            full_q, full_d;
  logic [XLEN-1:0] pc_q, pc_d, inst_q, inst_d;

  // load wins over clear so a same-cycle load/clear keeps the new word
  always_comb begin
    full_d = full_q;
    pc_d   = pc_q;
    inst_d = inst_q;
    if (clear) full_d = 1'b0;
    if (load) begin
      full_d = 1'b1;
      pc_d   = pc_in;
      inst_d = inst_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      pc_q   <= '0;
      inst_q <= '0;
    end else begin
      full_q <= full_d;
      pc_q   <= pc_d;
      inst_q <= inst_d;
    end
  end

  assign full     = full_q;
  assign pc_out   = pc_q;
  assign inst_out = inst_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC owner, one-outstanding imem reads, stall hold buffer, redirect flush.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall_cycles counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            if_en,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall_cycles,
`endif
  output logic            if_valid
);
  import fetch_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_inc;
  logic            discard_q, discard_d;
  logic            hb_load, hb_clear, hb_full;
  logic [XLEN-1:0] hb_pc, hb_inst;
  logic            outstanding;

  fetch_hold_buf #(.XLEN(XLEN)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load    (hb_load),
    .clear   (hb_clear),
    .pc_in   (pc_q),
    .inst_in (imem_rsp_data),
    .full    (hb_full),
    .pc_out  (hb_pc),
    .inst_out(hb_inst)
  );

  assign pc_inc = pc_q + XLEN'(PC_INC);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    discard_d      = discard_q;
    imem_req_valid = 1'b0;
    imem_addr      = pc_q;
    if_en          = 1'b0;
    if_valid       = 1'b0;
    if_pc          = '0;
    if_inst        = XLEN'(NOP_INST);
    hb_load        = 1'b0;
    hb_clear       = 1'b0;
    outstanding    = 1'b0;

    case (state_q)
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else if (stall) begin
            hb_load = 1'b1;
            state_d = S_HOLD;
          end else begin
            // deliver and issue the next fetch in the same cycle
            if_en          = 1'b1;
            if_valid       = 1'b1;
            if_pc          = pc_q;
            if_inst        = imem_rsp_data;
            pc_d           = pc_inc;
            imem_req_valid = 1'b1;
            imem_addr      = pc_inc;
            state_d        = imem_req_ready ? S_WAIT : S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          if_en    = 1'b1;
          if_valid = hb_full;
          if_pc    = hb_pc;
          if_inst  = hb_inst;
          pc_d     = pc_inc;
          hb_clear = 1'b1;
          state_d  = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // A request accepted this cycle in S_REQ counts as in flight.
    if (redirect_valid) begin
      outstanding    = (state_q == S_REQ && imem_req_ready) ||
                       (state_q == S_WAIT && !imem_rsp_valid);
      imem_req_valid = (state_q == S_REQ);
      imem_addr      = pc_q;
      if_en          = 1'b1;
      if_valid       = 1'b0;
      if_pc          = '0;
      if_inst        = XLEN'(NOP_INST);
      pc_d           = {redirect_pc[XLEN-1:2], 2'b00};
      hb_load        = 1'b0;
      hb_clear       = 1'b1;
      discard_d      = outstanding;
      state_d        = outstanding ? S_WAIT : S_REQ;
    end

    if (!rst) begin
      imem_req_valid = 1'b0;
      imem_addr      = pc_q;
      if_en          = 1'b0;
      if_valid       = 1'b0;
      if_pc          = '0;
      if_inst        = XLEN'(NOP_INST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_REQ;
      pc_q      <= XLEN'(RESET_PC);
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d, stall_cyc_q, stall_cyc_d;

  always_comb begin
    fetched_d   = fetched_q + {31'd0, (if_en && if_valid)};
    stall_cyc_d = stall_cyc_q + {31'd0, stall};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_q   <= '0;
      stall_cyc_q <= '0;
    end else begin
      fetched_q   <= fetched_d;
      stall_cyc_q <= stall_cyc_d;
    end
  end

  assign perf_fetched      = fetched_q;
  assign perf_stall_cycles = stall_cyc_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-outstanding instruction memory model.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        if_en;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  // memory model state
  logic        rsp_go = 1'b1;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;

  fetch_unit #(.RESET_PC(32'h0), .XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .if_en         (if_en),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched     (perf_fetched),
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .if_valid      (if_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; memory answers one cycle after acceptance unless rsp_go=0.
  task automatic tick();
    logic        acc, fired;
    logic [31:0] a;
    acc   = rst && imem_req_valid && imem_req_ready;
    fired = imem_rsp_valid;
    a     = imem_addr;
    @(posedge clk);
    #1;
    if (fired) pend = 1'b0;
    if (acc) begin
      pend  = 1'b1;
      paddr = a;
    end
    if (!rst) pend = 1'b0;
    imem_rsp_valid = pend && rsp_go;
    imem_rsp_data  = paddr ^ KEY;
  endtask

  task automatic deliver(input string tag, input logic [31:0] pc);
    chk({tag, ".en"},   {31'd0, if_en},    32'd1);
    chk({tag, ".vld"},  {31'd0, if_valid}, 32'd1);
    chk({tag, ".pc"},   if_pc,             pc);
    chk({tag, ".inst"}, if_inst,           pc ^ KEY);
  endtask

  initial begin
    // reset values
    #3;
    chk("rst.req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst.addr",      imem_addr,               32'h0);
    chk("rst.if_en",     {31'd0, if_en},          32'd0);
    chk("rst.if_valid",  {31'd0, if_valid},       32'd0);
    chk("rst.if_pc",     if_pc,                   32'h0);
    chk("rst.if_inst",   if_inst,                 NOP);
    tick();
    rst = 1'b1;
    #1;
    chk("c0.req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("c0.addr",      imem_addr,               32'h0);
    chk("c0.if_en",     {31'd0, if_en},          32'd0);

    // streaming 0, 4 at one per cycle
    tick(); #1; deliver("c1", 32'h0);
    chk("c1.next_addr", imem_addr, 32'h4);
    tick(); #1; deliver("c2", 32'h4);

    // stall for three cycles while pc 8 returns
    tick(); stall = 1'b1; #1;
    chk("stall0.en", {31'd0, if_en}, 32'd0);
    chk("stall0.req", {31'd0, imem_req_valid}, 32'd0);
    for (int i = 1; i < 3; i++) begin
      tick(); #1;
      chk("stallN.en", {31'd0, if_en}, 32'd0);
    end
    tick(); stall = 1'b0; #1; deliver("hold", 32'h8);
    tick(); #1;
    chk("post_hold.en", {31'd0, if_en}, 32'd0);
    chk("post_hold.addr", imem_addr, 32'hC);
    tick(); #1; deliver("c12", 32'hC);

    // redirect while 0x10 is in flight (response held back a cycle)
    rsp_go = 1'b0;
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
    chk("redir.en",   {31'd0, if_en},    32'd1);
    chk("redir.vld",  {31'd0, if_valid}, 32'd0);
    chk("redir.inst", if_inst,           NOP);
    chk("redir.req",  {31'd0, imem_req_valid}, 32'd0);
    rsp_go = 1'b1;
    tick(); redirect_valid = 1'b0; #1;
    chk("drop.rsp_seen", {31'd0, imem_rsp_valid}, 32'd1);
    chk("drop.en", {31'd0, if_en}, 32'd0);
    tick(); #1;
    chk("redir.addr", imem_addr, 32'h100);
    tick(); #1; deliver("r100", 32'h100);
    tick(); imem_req_ready = 1'b0; #1; deliver("r104", 32'h104);

    // memory not ready for four cycles
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("nrdy.addr", imem_addr, 32'h108);
      chk("nrdy.req",  {31'd0, imem_req_valid}, 32'd1);
      chk("nrdy.en",   {31'd0, if_en}, 32'd0);
    end
    tick(); imem_req_ready = 1'b1; #1;
    chk("rdy.addr", imem_addr, 32'h108);
    chk("rdy.en",   {31'd0, if_en}, 32'd0);
    tick(); #1; deliver("r108", 32'h108);

    // redirect beats stall and a live response; target near the top of memory
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; stall = 1'b1; #1;
    chk("redir2.en",  {31'd0, if_en},    32'd1);
    chk("redir2.vld", {31'd0, if_valid}, 32'd0);
    tick(); redirect_valid = 1'b0; stall = 1'b0; #1;
    chk("wrap.addr_top", imem_addr, 32'hFFFF_FFFC);
    chk("wrap.en", {31'd0, if_en}, 32'd0);
    tick(); #1; deliver("rtop", 32'hFFFF_FFFC);
    chk("wrap.addr0", imem_addr, 32'h0);
    tick(); #1; deliver("rwrap0", 32'h0);

    // reset while in the hold state
    tick(); stall = 1'b1; #1;
    chk("hold2.en", {31'd0, if_en}, 32'd0);
    tick(); #1;
    rst = 1'b0; #1;
    chk("rst2.req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst2.addr",      imem_addr,               32'h0);
    chk("rst2.if_en",     {31'd0, if_en},          32'd0);
    chk("rst2.if_pc",     if_pc,                   32'h0);
    chk("rst2.if_inst",   if_inst,                 NOP);
    tick(); rst = 1'b1; stall = 1'b0; #1;
    chk("restart.req",  {31'd0, imem_req_valid}, 32'd1);
    chk("restart.addr", imem_addr,               32'h0);
    tick(); #1; deliver("restart0", 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that produces the `{pc, inst}` word and the enable consumed by the IF/ID pipeline register (`DFF_fetch`). It owns the program counter and issues one-outstanding-request reads to instruction memory. It absorbs decode stalls in a one-entry hold buffer and handles branch/jump redirects from EX by discarding in-flight fetches and injecting a NOP bubble.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `XLEN`, 32, PC and instruction width

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `imem_req_valid` out 1: fetch request valid
- `imem_req_ready` in 1: memory accepts request this cycle
- `imem_addr` out XLEN: fetch address, stable while `imem_req_valid && !imem_req_ready`
- `imem_rsp_valid` in 1: read data valid, at least 1 cycle after acceptance
- `imem_rsp_data` in XLEN: instruction word
- `redirect_valid` in 1: EX-stage taken branch/jump
- `redirect_pc` in XLEN: redirect target
- `stall` in 1: hazard unit holds IF/ID
- `if_en` out 1: IF/ID capture enable (`DFF_fetch.en`)
- `if_pc` out XLEN: PC of delivered instruction
- `if_inst` out XLEN: delivered instruction, NOP 32'h0000_0013 when no valid instruction
- `if_valid` out 1: `if_inst` is a real fetched instruction

## Operation
- FSM states: `S_REQ` (drive request), `S_WAIT` (request accepted, awaiting response), `S_HOLD` (response buffered, stall active).
- `S_REQ`: `imem_req_valid=1`, `imem_addr=pc`. On `imem_req_ready` go to `S_WAIT`.
- `S_WAIT`, response with `!stall`: `if_en=1`, `if_valid=1`, `if_pc=pc`, `if_inst=imem_rsp_data`. `pc <= pc+4`. Next request (`pc+4`) is driven in the same cycle. If accepted, stay in `S_WAIT`; otherwise go to `S_REQ`.
- `S_WAIT`, response with `stall`: latch `{pc, data}` in the hold buffer and go to `S_HOLD`. `if_en=0`.
- `S_HOLD`: `if_en=0` while `stall`. On the first cycle with `!stall`, present the buffered word with `if_en=1`, `pc <= pc+4`, and go to `S_REQ`.
- Redirect (priority over stall and response):
  - `pc <= redirect_pc` and the hold buffer is cleared.
  - If a request is outstanding, set `discard`. The next response is dropped and clears `discard`.
  - `if_en=1`, `if_valid=0`, `if_inst=NOP` in the redirect cycle (flush bubble), even if `stall`.
  - Next state `S_REQ` if nothing is outstanding, otherwise `S_WAIT` with `discard`.
- `if_pc`/`if_inst`/`if_valid`/`if_en` are combinational from state, hold buffer and response. The registering is done by `DFF_fetch`.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC + 4 wraps to 0. The bottom two bits of `redirect_pc` are forced to 0.

## Timing
- Reset (`rst`=0, async): `pc=RESET_PC`, state `S_REQ`, `discard=0`, hold buffer empty.
  - During reset: `imem_req_valid=0`, `imem_addr=RESET_PC`, `if_en=0`, `if_valid=0`, `if_pc=0`, `if_inst=NOP`.
  - The first request is driven in the first cycle after `rst` rises.
- Latency: request accepted at edge N, response in cycle N+k (k≥1), IF/ID captures at the edge ending that cycle.
- Throughput: 1 instruction/cycle with a zero-wait memory (k=1, ready=1).
- `stall` and response in the same cycle: the word goes to the hold buffer and is never lost or duplicated.
- Reset asserted mid-request: the outstanding request is forgotten. The memory must also be reset.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds outputs `perf_fetched` (32 b, counts `if_en && if_valid`) and `perf_stall_cycles` (32 b, counts cycles with `stall`). Both reset to 0 and wrap.
- Undefined: ports and counters are absent. Functional behaviour is identical.

## Structure
- `fetch_pkg`: `XLEN`, `NOP_INST = 32'h0000_0013`, `PC_INC = 4`, FSM state encoding.
- Sub-module `fetch_hold_buf`: one-entry `{pc, inst}` register with load/clear/full.

## Test plan
- Reset release, ready=1, 1-cycle response: IF/ID sees pc 0,4,8,… on consecutive cycles with `if_valid=1`.
- `stall` high 3 cycles while a response for pc 8 arrives: `if_en=0` for 3 cycles, then pc 8 delivered exactly once, then pc 12.
- `redirect_valid` with target 32'h0000_0100 while pc 0x10 is in flight: the 0x10 response is dropped, one NOP bubble (`if_valid=0`), then 0x100, 0x104.
- `imem_req_ready=0` for 4 cycles: `imem_addr` is stable and no `if_en` until accepted.
- pc 32'hFFFF_FFFC fetched: next `imem_addr` is 0.
- `rst` asserted in `S_HOLD`: outputs return to reset values immediately and fetch restarts at `RESET_PC`.
